// File: rtl/pp_pkg.sv
// Shared types for the plane parity engine: FSM states and mode encodings.
package pp_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StEmit, StFin} state_e;

  localparam logic ModeTheta  = 1'b0;
  localparam logic ModeBypass = 1'b1;

endpackage

// File: rtl/plane_parity_engine_if.sv
// Row streams into and out of the plane parity engine (valid/ready both ways).
interface plane_parity_engine_if #(
  parameter int unsigned W = 5
) ();

  logic         in_valid;
  logic [W-1:0] in_row;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_row;
  logic         out_ready;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row
  );

endinterface

// File: rtl/pp_mask.sv
// Neighbour-parity mask: d[x] = c[x-1] ^ c[x+1] with wrap-around at both plane edges.
module pp_mask #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] c_i,
  output logic [W-1:0] d_o
);

  for (genvar x = 0; x < W; x++) begin : g_col
    assign d_o[x] = c_i[(x + W - 1) % W] ^ c_i[(x + 1) % W];
  end

endmodule

// File: rtl/plane_parity_engine.sv
// Column-parity (theta) engine: loads W rows, computes the neighbour-parity mask, then
// streams the rows back out XORed with it, PLANES times per start.
module plane_parity_engine
  import pp_pkg::*;
#(
  parameter int unsigned W      = 5,
  parameter int unsigned PLANES = 64,
  parameter int unsigned PW     = $clog2(PLANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  plane_parity_engine_if.slave   strm,
  output logic                   busy,
  output logic                   done,
  output logic [PW-1:0]          plane_idx
);

  localparam int unsigned RW = $clog2(W);
  localparam logic [RW-1:0] LastRow   = RW'(W - 1);
  localparam logic [PW-1:0] LastPlane = PW'(PLANES - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_next;
  logic [W-1:0]  row_buf_q [W];
  logic [W-1:0]  c_q, d_q, out_row_q, mask_d, d_eff;
  logic [PW-1:0] plane_q;
  logic          mode_q;
  logic          in_fire, out_fire, last_row;

  assign in_fire  = strm.in_valid & strm.in_ready;
  assign out_fire = strm.out_valid & strm.out_ready;
  assign last_row = (row_q == LastRow);
  assign row_next = row_q + 1'b1;

  pp_mask #(.W(W)) u_mask (
    .c_i(c_q),
    .d_o(mask_d)
  );

  assign d_eff = (mode_q == ModeBypass) ? '0 : mask_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: if (in_fire && last_row) state_d = StCalc;
      StCalc: state_d = StEmit;
      StEmit: begin
        if (out_fire && last_row) state_d = (plane_q == LastPlane) ? StFin : StLoad;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    strm.in_ready  = (state_q == StLoad);
    strm.out_valid = (state_q == StEmit);
    strm.out_row   = out_row_q;
    busy           = (state_q != StIdle);
    done           = (state_q == StFin);
    plane_idx      = plane_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q     <= '0;
      c_q       <= '0;
      d_q       <= '0;
      out_row_q <= '0;
      plane_q   <= '0;
      mode_q    <= ModeTheta;
      for (int r = 0; r < W; r++) row_buf_q[r] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            plane_q <= '0;
            row_q   <= '0;
            c_q     <= '0;
          end
        end
        StLoad: begin
          if (in_fire) begin
            row_buf_q[row_q] <= strm.in_row;
            c_q              <= c_q ^ strm.in_row;
            row_q            <= last_row ? '0 : row_next;
          end
        end
        StCalc: begin
          // First output row is registered here so it is ready on EMIT entry.
          d_q       <= d_eff;
          out_row_q <= row_buf_q[0] ^ d_eff;
        end
        StEmit: begin
          if (out_fire) begin
            if (last_row) begin
              row_q     <= '0;
              out_row_q <= '0;
              if (plane_q != LastPlane) begin
                plane_q <= plane_q + 1'b1;
                c_q     <= '0;
              end
            end else begin
              row_q     <= row_next;
              out_row_q <= row_buf_q[row_next] ^ d_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plane_parity_engine.sv
// Directed bench for plane_parity_engine: a W=5/PLANES=3 instance and a W=7/PLANES=1 instance.
module tb_plane_parity_engine;
  import pp_pkg::*;

  typedef logic [4:0] plane_t [5];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   a_done_cnt = 0;

  logic       a_start = 1'b0, a_mode = 1'b0, a_busy, a_done;
  logic [1:0] a_pidx;
  logic       b_start = 1'b0, b_mode = 1'b0, b_busy, b_done;
  logic [0:0] b_pidx;

  plane_parity_engine_if #(.W(5)) a_if ();
  plane_parity_engine_if #(.W(7)) b_if ();

  plane_parity_engine #(.W(5), .PLANES(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .strm(a_if),
    .busy(a_busy), .done(a_done), .plane_idx(a_pidx)
  );

  plane_parity_engine #(.W(7), .PLANES(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .strm(b_if),
    .busy(b_busy), .done(b_done), .plane_idx(b_pidx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (a_done) a_done_cnt++;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic plane_t theta(input plane_t p, input logic m);
    logic [4:0] c = '0;
    logic [4:0] d;
    plane_t     o;
    for (int r = 0; r < 5; r++) c ^= p[r];
    for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ c[(x + 1) % 5];
    if (m) d = '0;
    for (int r = 0; r < 5; r++) o[r] = p[r] ^ d;
    return o;
  endfunction

  function automatic plane_t rand_plane();
    plane_t p;
    for (int r = 0; r < 5; r++) p[r] = 5'($urandom);
    return p;
  endfunction

  // All tasks enter and leave one time unit after a rising edge.
  task automatic a_go(input logic m);
    a_mode  = m;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_feed(input logic [4:0] row, input int gap);
    int n = 0;
    a_if.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    a_if.in_valid = 1'b1;
    a_if.in_row   = row;
    @(negedge clk);
    while (!a_if.in_ready && n < 40) begin @(negedge clk); n++; end
    chk("load_ready", 32'(a_if.in_ready), 32'(1));
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic a_take(input logic [4:0] exp, input int stall, input logic [1:0] pidx,
                        input string tag);
    int n = 0;
    a_if.out_ready = 1'b0;
    @(negedge clk);
    while (!a_if.out_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(a_if.out_valid), 32'(1));
    repeat (stall) begin
      chk({tag, "_stall"}, 32'({a_if.out_valid, a_if.out_row}), 32'({1'b1, exp}));
      @(negedge clk);
    end
    chk(tag, 32'(a_if.out_row), 32'(exp));
    chk({tag, "_pidx"}, 32'(a_pidx), 32'(pidx));
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.out_ready = 1'b0;
  endtask

  task automatic a_plane(input plane_t p, input plane_t e, input logic [1:0] pidx,
                         input int gapmax, input bit stalls, input string tag);
    for (int r = 0; r < 5; r++) a_feed(p[r], $urandom_range(0, gapmax));
    for (int r = 0; r < 5; r++) a_take(e[r], (stalls && (r % 2 == 1)) ? 2 : 0, pidx, tag);
  endtask

  task automatic a_check_done(input int cnt0, input string tag);
    @(negedge clk);
    chk({tag, "_done_hi"}, 32'({a_done, a_busy}), 32'(2'b11));
    @(negedge clk);
    chk({tag, "_done_lo"}, 32'({a_done, a_busy, a_if.in_ready, a_if.out_valid}), 32'(0));
    chk({tag, "_done_cnt"}, 32'(a_done_cnt - cnt0), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    plane_t p0, p1, p2, e0, e1, e2, z;
    int     cnt0;
    int     n;

    a_if.in_valid = 1'b0; a_if.in_row = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_row = '0; b_if.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outs", 32'({a_if.in_ready, a_if.out_valid, a_if.out_row, a_busy, a_done, a_pidx}),
        32'(0));
    chk("rst_b_outs", 32'({b_if.in_ready, b_if.out_valid, b_if.out_row, b_busy, b_done, b_pidx}),
        32'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed theta planes: single bit, all ones, all zeros
    p0 = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    e0 = '{5'b10011, 5'b10010, 5'b10010, 5'b10010, 5'b10010};
    p1 = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
    p2 = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    z  = p2;
    cnt0 = a_done_cnt;
    a_go(ModeTheta);
    a_plane(p0, e0, 2'd0, 0, 1'b0, "theta_bit");
    a_plane(p1, p1, 2'd1, 0, 1'b0, "theta_ones");
    a_plane(p2, z, 2'd2, 0, 1'b0, "theta_zero");
    a_check_done(cnt0, "theta");

    // Bypass: rows come back unchanged, with input gaps and output stalls
    p0 = '{5'b10110, 5'b01101, 5'b11100, 5'b00011, 5'b10001};
    p1 = '{5'b01010, 5'b11001, 5'b00111, 5'b10100, 5'b01111};
    p2 = '{5'b11011, 5'b00100, 5'b01001, 5'b11110, 5'b10000};
    cnt0 = a_done_cnt;
    a_go(ModeBypass);
    a_plane(p0, p0, 2'd0, 2, 1'b1, "bypass0");
    a_plane(p1, p1, 2'd1, 2, 1'b1, "bypass1");
    a_plane(p2, p2, 2'd2, 2, 1'b1, "bypass2");
    a_check_done(cnt0, "bypass");

    // Random theta planes checked against the model, with stalls and gaps
    p0 = rand_plane(); p1 = rand_plane(); p2 = rand_plane();
    e0 = theta(p0, 1'b0); e1 = theta(p1, 1'b0); e2 = theta(p2, 1'b0);
    cnt0 = a_done_cnt;
    a_go(ModeTheta);
    a_plane(p0, e0, 2'd0, 2, 1'b1, "rand0");
    a_plane(p1, e1, 2'd1, 2, 1'b1, "rand1");
    a_plane(p2, e2, 2'd2, 2, 1'b1, "rand2");
    a_check_done(cnt0, "rand");

    // Reset during EMIT of plane 1 abandons the run
    a_go(ModeTheta);
    a_plane(p0, e0, 2'd0, 0, 1'b0, "mid0");
    for (int r = 0; r < 5; r++) a_feed(p1[r], 0);
    n = 0;
    @(negedge clk);
    while (!a_if.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("mid_emit", 32'({a_if.out_valid, a_pidx}), 32'({1'b1, 2'd1}));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", 32'({a_if.in_ready, a_if.out_valid, a_if.out_row, a_busy, a_done, a_pidx}),
        32'(0));
    rst = 1'b1;
    a_if.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_idle", 32'({a_if.out_valid, a_busy}), 32'(0));
    end
    a_if.out_ready = 1'b0;
    @(posedge clk); #1;

    // Fresh start after reset
    p0 = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    e0 = '{5'b10011, 5'b10010, 5'b10010, 5'b10010, 5'b10010};
    cnt0 = a_done_cnt;
    a_go(ModeTheta);
    a_plane(p0, e0, 2'd0, 1, 1'b0, "fresh0");
    a_plane(p1, e1, 2'd1, 0, 1'b0, "fresh1");
    a_plane(p2, e2, 2'd2, 0, 1'b0, "fresh2");
    a_check_done(cnt0, "fresh");

    // W=7: single bit at column 6 of row 3 wraps to columns 5 and 0
    b_mode  = ModeTheta;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      b_if.in_valid = 1'b1;
      b_if.in_row   = (r == 3) ? 7'b1000000 : 7'b0000000;
      @(negedge clk);
      chk("w7_in_ready", 32'(b_if.in_ready), 32'(1));
      @(posedge clk); #1;
    end
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      n = 0;
      @(negedge clk);
      while (!b_if.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("w7_row", 32'({b_if.out_valid, b_if.out_row}),
          32'({1'b1, ((r == 3) ? 7'b1100001 : 7'b0100001)}));
      @(posedge clk); #1;
    end
    b_if.out_ready = 1'b0;
    @(negedge clk);
    chk("w7_done", 32'({b_done, b_pidx}), 32'({1'b1, 1'b0}));
    @(negedge clk);
    chk("w7_idle", 32'({b_done, b_busy}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
